jtsbaskt_sndcmd: RTL and testbench

Main-to-sound command queue for the Super Basketball sound board. It sits directly upstream of the sound CPU subsystem, between the main CPU's sound-latch and sound-IRQ write decodes and the sound board's `main_dout`, `m2s_data` and `m2s_on` inputs. Commands written back-to-back by the main CPU are buffered in a small FIFO. They are delivered one at a time: latch load, then IRQ edge, then wait until the sound CPU reads the latch or a timeout expires. This prevents command loss when the sound CPU is slower than the main CPU.

---
 rtl/jtsbaskt_sndcmd.sv | 189 ++++++++++++++++++
 tb/tb_jtsbaskt_sndcmd.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtsbaskt_sndcmd.sv
`default_nettype none
// ============================================================================
// Module   : jtsbaskt_sndcmd
// Purpose  : Main-to-sound command queue. Buffers sound commands written by
//            the main CPU and hands them to the sound board one at a time:
//            latch load, IRQ pulse, then wait for the sound CPU to read the
//            latch or for a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module jtsbaskt_sndcmd #(
  parameter int AW   = 2,
  parameter int IRQW = 4,
  parameter int TMO  = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          snd_cen,
  input  logic [7:0]    main_dout,
  input  logic          latch_we,
  input  logic          irq_we,
  input  logic          snd_rd,
  input  logic          ovf_clr,
  output logic [7:0]    snd_dout,
  output logic          m2s_data,
  output logic          m2s_on,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          ovf
);

  localparam int            c_DEPTH   = 1 << AW;
  localparam logic [AW:0]   c_FULL    = (AW+1)'(c_DEPTH);
  localparam logic [AW:0]   c_LVL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
  localparam logic [9:0]    c_IRQW    = 10'(IRQW);
  localparam logic [9:0]    c_TMO     = 10'(TMO);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_IRQ  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t        r_state;
  logic [7:0]    r_stg;
  logic [7:0]    r_mem [c_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [9:0]    r_tc;
  logic          r_ack;

  logic [7:0]    w_push_data;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;
  logic [AW:0]   w_level_nxt;
  logic [9:0]    w_tc_inc;

  // A write to both addresses in one cycle must queue the fresh byte, not the old staging value
  assign w_push_data = latch_we ? main_dout : r_stg;
  assign w_full      = (level == c_FULL);
  assign w_pop       = (r_state == ST_IDLE) && (level != '0);
  // A pop in the same cycle frees a slot, so a push into a full queue is still taken
  assign w_push_ok   = irq_we && (!w_full || w_pop);
  assign w_drop      = irq_we && w_full && !w_pop;
  assign w_tc_inc    = r_tc + 10'd1;

  // Occupancy after this cycle's push/pop
  always_comb begin
    w_level_nxt = level;
    if (w_push_ok && !w_pop) begin
      w_level_nxt = level + c_LVL_ONE;
    end else if (!w_push_ok && w_pop) begin
      w_level_nxt = level - c_LVL_ONE;
    end
  end

  // Staging register for the latch write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stg <= 8'd0;
    end else if (latch_we) begin
      r_stg <= main_dout;
    end
  end

  // Queue storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wp] <= w_push_data;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      level <= '0;
    end else begin
      if (w_push_ok) begin
        r_wp <= r_wp + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rp <= r_rp + c_PTR_ONE;
      end
      level <= w_level_nxt;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (w_drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Delivery sequencer: load latch, pulse IRQ, wait for ack or timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      snd_dout <= 8'd0;
      m2s_data <= 1'b0;
      m2s_on   <= 1'b0;
      r_tc     <= 10'd0;
      r_ack    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      m2s_data <= 1'b0;
      busy     <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            snd_dout <= r_mem[r_rp];
            m2s_data <= 1'b1;
            r_state  <= ST_LOAD;
          end else begin
            busy <= (w_level_nxt != '0);
          end
        end
        ST_LOAD: begin
          r_tc    <= 10'd0;
          // An ack arriving while the latch loads still counts
          r_ack   <= snd_rd;
          m2s_on  <= 1'b1;
          r_state <= ST_IRQ;
        end
        ST_IRQ: begin
          if (snd_rd) begin
            r_ack <= 1'b1;
          end
          if (snd_cen) begin
            if (w_tc_inc == c_IRQW) begin
              r_tc    <= 10'd0;
              m2s_on  <= 1'b0;
              r_state <= ST_WAIT;
            end else begin
              r_tc <= w_tc_inc;
            end
          end
        end
        ST_WAIT: begin
          if (snd_rd) begin
            r_ack <= 1'b1;
          end
          if (snd_cen) begin
            r_tc <= w_tc_inc;
          end
          if (r_ack || (snd_cen && (w_tc_inc == c_TMO))) begin
            r_state <= ST_IDLE;
            busy    <= (w_level_nxt != '0);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          m2s_on  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtsbaskt_sndcmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtsbaskt_sndcmd
// Purpose  : Self-checking bench for the main-to-sound command queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtsbaskt_sndcmd;

  localparam int AW   = 2;
  localparam int IRQW = 4;
  localparam int TMO  = 1023;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         snd_cen = 1'b0;
  logic [7:0]   main_dout = 8'd0;
  logic         latch_we = 1'b0;
  logic         irq_we = 1'b0;
  logic         snd_rd = 1'b0;
  logic         ovf_clr = 1'b0;
  logic [7:0]   snd_dout;
  logic         m2s_data;
  logic         m2s_on;
  logic [AW:0]  level;
  logic         busy;
  logic         ovf;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cen_div = 1;
  int cen_cnt = 0;
  int on_ticks = 0;
  int last_on_ticks = 0;
  logic prev_on = 1'b0;

  logic [7:0]  sb[$];
  int          log_cyc[$];
  logic [AW:0] log_lvl[$];

  jtsbaskt_sndcmd #(.AW(AW), .IRQW(IRQW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .snd_cen(snd_cen), .main_dout(main_dout),
    .latch_we(latch_we), .irq_we(irq_we), .snd_rd(snd_rd), .ovf_clr(ovf_clr),
    .snd_dout(snd_dout), .m2s_data(m2s_data), .m2s_on(m2s_on),
    .level(level), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Clock enable, updated just after each rising edge
  always begin
    @(posedge clk);
    #1;
    cen_cnt = (cen_cnt + 1 >= cen_div) ? 0 : cen_cnt + 1;
    snd_cen = (cen_cnt == 0);
  end

  // Monitor: every latch load pops the scoreboard; IRQ ticks are counted
  always @(negedge clk) begin
    if (rst) begin
      on_ticks = 0;
      prev_on  = 1'b0;
    end else begin
      if (m2s_data === 1'b1) begin
        logic [7:0] exp_b;
        log_cyc.push_back(cyc);
        log_lvl.push_back(level);
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_load: snd_dout=%h with no command expected", snd_dout);
        end else begin
          exp_b = sb.pop_front();
          if (snd_dout !== exp_b) begin
            fails++;
            $display("FAIL delivered_byte: got %h expected %h", snd_dout, exp_b);
          end
        end
        tests++;
        if (m2s_on !== 1'b0) begin
          fails++;
          $display("FAIL load_irq_overlap: m2s_on=%b expected 0", m2s_on);
        end
      end
      if (m2s_on === 1'b1 && snd_cen) on_ticks++;
      if (prev_on && m2s_on === 1'b0) begin
        last_on_ticks = on_ticks;
        on_ticks = 0;
      end
      prev_on = (m2s_on === 1'b1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle_timeout: busy=%b expected 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests += 6;
    if (snd_dout !== 8'd0) begin fails++; $display("FAIL rst_snd_dout: got %h expected 00", snd_dout); end
    if (m2s_data !== 1'b0) begin fails++; $display("FAIL rst_m2s_data: got %b expected 0", m2s_data); end
    if (m2s_on !== 1'b0)   begin fails++; $display("FAIL rst_m2s_on: got %b expected 0", m2s_on); end
    if (level !== 3'd0)    begin fails++; $display("FAIL rst_level: got %0d expected 0", level); end
    if (busy !== 1'b0)     begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (ovf !== 1'b0)      begin fails++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n = 0;
    cen_div = 3;
    latch_we = 1'b1; main_dout = 8'h5A;
    @(negedge clk);
    latch_we = 1'b0; main_dout = 8'h00; irq_we = 1'b1;
    sb.push_back(8'h5A);
    @(negedge clk);
    irq_we = 1'b0;
    tests++;
    if (level !== 3'd1) begin fails++; $display("FAIL single_level_n1: got %0d expected 1", level); end
    @(negedge clk);
    tests += 2;
    if (m2s_data !== 1'b1) begin fails++; $display("FAIL single_load_n2: got %b expected 1", m2s_data); end
    if (snd_dout !== 8'h5A) begin fails++; $display("FAIL single_dout_n2: got %h expected 5a", snd_dout); end
    @(negedge clk);
    tests += 2;
    if (m2s_on !== 1'b1) begin fails++; $display("FAIL single_irq_n3: got %b expected 1", m2s_on); end
    if (m2s_data !== 1'b0) begin fails++; $display("FAIL single_load_1cyc: got %b expected 0", m2s_data); end
    while (m2s_on === 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    tests++;
    if (last_on_ticks != IRQW) begin
      fails++;
      $display("FAIL single_irq_ticks: got %0d expected %0d", last_on_ticks, IRQW);
    end
    snd_rd = 1'b1;
    @(negedge clk);
    snd_rd = 1'b0;
    repeat (3) @(negedge clk);
    tests += 3;
    if (busy !== 1'b0)  begin fails++; $display("FAIL single_busy_after_ack: got %b expected 0", busy); end
    if (level !== 3'd0) begin fails++; $display("FAIL single_level_end: got %0d expected 0", level); end
    if (sb.size() != 0) begin fails++; $display("FAIL single_undelivered: got %0d left expected 0", sb.size()); end
    cen_div = 1;
  endtask

  task automatic test_burst();
    int base;
    logic [AW:0] exp_lvl [4] = '{3'd0, 3'd2, 3'd1, 3'd0};
    cen_div = 1;
    base = log_cyc.size();
    for (int i = 0; i < 4; i++) begin
      irq_we = 1'b0; latch_we = 1'b1; main_dout = 8'(i + 1);
      @(negedge clk);
      latch_we = 1'b0; main_dout = 8'h00; irq_we = 1'b1;
      sb.push_back(8'(i + 1));
      @(negedge clk);
    end
    irq_we = 1'b0;
    wait_idle(6000, "burst");
    tests++;
    if (log_cyc.size() - base != 4) begin
      fails++;
      $display("FAIL burst_count: got %0d loads expected 4", log_cyc.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (log_lvl[base+k] !== exp_lvl[k]) begin
          fails++;
          $display("FAIL burst_level_%0d: got %0d expected %0d", k, log_lvl[base+k], exp_lvl[k]);
        end
        if (k > 0) begin
          tests++;
          if (log_cyc[base+k] - log_cyc[base+k-1] != IRQW + TMO + 2) begin
            fails++;
            $display("FAIL burst_spacing_%0d: got %0d expected %0d", k,
                     log_cyc[base+k] - log_cyc[base+k-1], IRQW + TMO + 2);
          end
        end
      end
    end
    tests += 2;
    if (ovf !== 1'b0) begin fails++; $display("FAIL burst_ovf: got %b expected 0", ovf); end
    if (sb.size() != 0) begin fails++; $display("FAIL burst_undelivered: got %0d left expected 0", sb.size()); end
  endtask

  // Overflow, simultaneous write bypass, full push+pop and early-ack spacing
  task automatic test_overflow_and_early_ack();
    int base;
    int n;
    cen_div = 1;
    base = log_cyc.size();
    for (int i = 0; i < 6; i++) begin
      latch_we = 1'b1; irq_we = 1'b1; main_dout = 8'(8'h10 + i);
      if (i < 5) sb.push_back(8'(8'h10 + i));
      @(negedge clk);
    end
    latch_we = 1'b0; irq_we = 1'b0; main_dout = 8'h00;
    tests += 2;
    if (ovf !== 1'b1)   begin fails++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    if (level !== 3'd4) begin fails++; $display("FAIL ovf_level_full: got %0d expected 4", level); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    @(negedge clk);
    tests++;
    if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
    n = 0;
    while (m2s_on !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    snd_rd = 1'b1;
    @(negedge clk);
    snd_rd = 1'b0;
    @(negedge clk);
    // Sequencer is idle this cycle and pops; push a fresh bypassed byte into the full queue
    latch_we = 1'b1; irq_we = 1'b1; main_dout = 8'hC3;
    sb.push_back(8'hC3);
    @(negedge clk);
    latch_we = 1'b0; irq_we = 1'b0; main_dout = 8'h00;
    tests += 3;
    if (level !== 3'd4)    begin fails++; $display("FAIL full_pushpop_level: got %0d expected 4", level); end
    if (m2s_data !== 1'b1) begin fails++; $display("FAIL full_pushpop_load: got %b expected 1", m2s_data); end
    if (ovf !== 1'b0)      begin fails++; $display("FAIL full_pushpop_ovf: got %b expected 0", ovf); end
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (m2s_on !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      tests++;
      if (m2s_on !== 1'b1) begin fails++; $display("FAIL early_ack_irq_%0d: m2s_on=%b expected 1", j, m2s_on); end
      snd_rd = 1'b1;
      @(negedge clk);
      snd_rd = 1'b0;
      n = 0;
      while (m2s_on !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    end
    wait_idle(100, "early_ack");
    tests++;
    if (log_cyc.size() - base != 6) begin
      fails++;
      $display("FAIL ovf_load_count: got %0d loads expected 6", log_cyc.size() - base);
    end else begin
      for (int k = 2; k < 6; k++) begin
        tests++;
        if (log_cyc[base+k] - log_cyc[base+k-1] != IRQW + 3) begin
          fails++;
          $display("FAIL early_ack_spacing_%0d: got %0d expected %0d", k,
                   log_cyc[base+k] - log_cyc[base+k-1], IRQW + 3);
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL ovf_undelivered: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid_irq();
    int cnt;
    cen_div = 1;
    for (int i = 0; i < 4; i++) begin
      latch_we = 1'b1; irq_we = 1'b1; main_dout = 8'(8'h20 + i);
      if (i == 0) sb.push_back(8'h20);
      @(negedge clk);
    end
    latch_we = 1'b0; irq_we = 1'b0; main_dout = 8'h00;
    tests += 2;
    if (m2s_on !== 1'b1) begin fails++; $display("FAIL rstmid_irq_high: got %b expected 1", m2s_on); end
    if (level !== 3'd3)  begin fails++; $display("FAIL rstmid_level_pre: got %0d expected 3", level); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests += 2;
    if (m2s_on !== 1'b0) begin fails++; $display("FAIL rstmid_irq_low: got %b expected 0", m2s_on); end
    if (level !== 3'd0)  begin fails++; $display("FAIL rstmid_level_post: got %0d expected 0", level); end
    cnt = log_cyc.size();
    repeat (50) @(negedge clk);
    tests += 3;
    if (log_cyc.size() != cnt) begin
      fails++;
      $display("FAIL rstmid_no_load: got %0d loads expected 0", log_cyc.size() - cnt);
    end
    if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    if (sb.size() != 0) begin fails++; $display("FAIL rstmid_undelivered: got %0d left expected 0", sb.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_overflow_and_early_ack();
    test_reset_mid_irq();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
